// File: rtl/vlsu_addr_sequencer.sv
// Vector load/store address sequencer.
// Issues one element access per bus beat for unit-strided and strided
// VLOAD/VSTORE instructions. It produces the byte address, byte enables and
// element index for each beat. Write data and load writeback live in the
// vector datapath, which is keyed by elem_idx_o.
module vlsu_addr_sequencer #(
   parameter int VLEN = 256,
   parameter int VL_W = $clog2(VLEN/8) + 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start_i,
   input  logic            kill_i,
   input  logic            is_store_i,
   input  logic [1:0]      addr_mode_i,
   input  logic [2:0]      eew_i,
   input  logic [31:0]     base_addr_i,
   input  logic [31:0]     stride_i,
   input  logic [VL_W-1:0] vl_i,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [31:0]     mem_addr_o,
   output logic [3:0]      mem_be_o,
   input  logic            mem_gnt_i,
   output logic [VL_W-1:0] elem_idx_o,
   output logic            busy_o,
   output logic            done_o,
   output logic            error_o
);

   typedef enum logic [1:0] {
      VLSU_IDLE,
      VLSU_FIRST_CYCLE,
      VLSU_EXEC,
      VLSU_LAST_CYCLE
   } vector_lsu_states_e;

   typedef enum logic [1:0] {
      UNIT_STRIDED      = 2'd0,
      STRIDED           = 2'd1,
      INDEXED_UNORDERED = 2'd2,
      INDEXED_ORDERED   = 2'd3
   } addrModes_e;

   typedef enum logic [2:0] {
      EW8  = 3'd0,
      EW16 = 3'd1,
      EW32 = 3'd2,
      EW64 = 3'd3
   } vew_e;

   vector_lsu_states_e state_q, state_d;

   logic [31:0]     cur_addr_q;
   logic [31:0]     stride_q;
   logic [VL_W-1:0] vl_q;
   logic [VL_W-1:0] elem_idx_q;
   vew_e            eew_q;
   logic            we_q;
   logic            err_q;

   logic aligned;
   logic last_elem;
   logic cfg_bad;
   logic clear_err;
   logic latch_cfg;
   logic set_err;
   logic advance;

   // Indexed modes are not supported, and nothing wider than 32 bits fits the port.
   assign cfg_bad   = addr_mode_i[1] | (eew_i > EW32);
   assign last_elem = (elem_idx_q == (vl_q - VL_W'(1)));

   // Alignment of the current element against its own width.
   always_comb begin
      aligned = 1'b0;
      case (eew_q)
         EW8:     aligned = 1'b1;
         EW16:    aligned = ~cur_addr_q[0];
         EW32:    aligned = (cur_addr_q[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   // State register; an async reset drops any outstanding request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= VLSU_IDLE;
      else          state_q <= state_d;
   end

   // Next-state and output decode; kill wins over grant and error paths.
   always_comb begin
      state_d    = state_q;
      mem_req_o  = 1'b0;
      mem_we_o   = 1'b0;
      mem_addr_o = 32'd0;
      mem_be_o   = 4'd0;
      elem_idx_o = '0;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      error_o    = 1'b0;
      clear_err  = 1'b0;
      latch_cfg  = 1'b0;
      set_err    = 1'b0;
      advance    = 1'b0;
      case (state_q)
         VLSU_IDLE: begin
            if (start_i) begin
               state_d   = VLSU_FIRST_CYCLE;
               clear_err = 1'b1;
            end
         end
         VLSU_FIRST_CYCLE: begin
            busy_o = 1'b1;
            if (kill_i) begin
               state_d = VLSU_IDLE;
            end else begin
               latch_cfg = 1'b1;
               if (cfg_bad || (vl_i == '0)) state_d = VLSU_LAST_CYCLE;
               else                         state_d = VLSU_EXEC;
            end
         end
         VLSU_EXEC: begin
            busy_o     = 1'b1;
            mem_addr_o = cur_addr_q;
            mem_we_o   = we_q;
            elem_idx_o = elem_idx_q;
            case (eew_q)
               EW8:     mem_be_o = 4'b0001 << cur_addr_q[1:0];
               EW16:    mem_be_o = 4'b0011 << cur_addr_q[1:0];
               default: mem_be_o = 4'b1111;
            endcase
            if (kill_i) begin
               state_d = VLSU_IDLE;
            end else if (!aligned) begin
               set_err = 1'b1;
               state_d = VLSU_LAST_CYCLE;
            end else begin
               mem_req_o = 1'b1;
               if (mem_gnt_i) begin
                  if (last_elem) state_d = VLSU_LAST_CYCLE;
                  else           advance = 1'b1;
               end
            end
         end
         VLSU_LAST_CYCLE: begin
            busy_o  = 1'b1;
            state_d = VLSU_IDLE;
            if (!kill_i) begin
               done_o  = 1'b1;
               error_o = err_q;
            end
         end
         default: state_d = VLSU_IDLE;
      endcase
   end

   // Configuration latch and per-element address/index stepping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_addr_q <= 32'd0;
         stride_q   <= 32'd0;
         vl_q       <= '0;
         elem_idx_q <= '0;
         eew_q      <= EW8;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (clear_err) err_q <= 1'b0;
         if (latch_cfg) begin
            cur_addr_q <= base_addr_i;
            elem_idx_q <= '0;
            we_q       <= is_store_i;
            eew_q      <= vew_e'(eew_i);
            vl_q       <= vl_i;
            stride_q   <= (addr_mode_i == UNIT_STRIDED) ? (32'd1 << eew_i) : stride_i;
            err_q      <= cfg_bad;
         end
         if (set_err) err_q <= 1'b1;
         if (advance) begin
            elem_idx_q <= elem_idx_q + VL_W'(1);
            cur_addr_q <= cur_addr_q + stride_q;
         end
      end
   end

endmodule
